// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared types and constants
// for the FIFO-fed serial transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic TX_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-time down-counter.
// bit_end marks the last cycle of a bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic bit_end,
  output logic bit_near
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] TOP = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  // reload at each bit start, else count down to zero and hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TOP;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // bit_near leads bit_end by one cycle
  always_comb begin
    bit_end  = enable && (cnt == '0);
    bit_near = enable && (cnt == W'(1));
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the FIFO and
// shifts them out as async serial frames.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       f_empty,
  input  logic [7:0] f_out,
  output logic       rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t state, state_d;

  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par, par_d;
  logic [2:0]           bcnt, bcnt_d;
  logic                 scnt, scnt_d;
  logic                 tx_d, rd_d, done_d;
  logic                 load, tick_en;
  logic                 bit_end, bit_near;
  logic                 last_stop;

  assign last_stop = (scnt == LAST_STOP);
  assign tick_en   = state inside {START, DATA, PARITY, STOP};

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .enable  (tick_en),
    .bit_end (bit_end),
    .bit_near(bit_near)
  );

  // next-state, next-output and datapath decode
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    par_d   = par;
    bcnt_d  = bcnt;
    scnt_d  = scnt;
    tx_d    = tx;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        tx_d = TX_IDLE_LVL;
        if (en && !f_empty) begin
          state_d = POP;
          rd_d    = 1'b1;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d = f_out;
        par_d   = ^f_out;
        bcnt_d  = '0;
        scnt_d  = 1'b0;
        load    = 1'b1;
        state_d = START;
        tx_d    = 1'b0;
      end
      START: begin
        if (bit_end) begin
          load    = 1'b1;
          state_d = DATA;
          tx_d    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          load    = 1'b1;
          shreg_d = shreg >> 1;
          bcnt_d  = bcnt + 3'd1;
          if (bcnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par;
            end else begin
              state_d = STOP;
              tx_d    = TX_IDLE_LVL;
            end
          end else begin
            tx_d = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          load    = 1'b1;
          state_d = STOP;
          tx_d    = TX_IDLE_LVL;
        end
      end
      STOP: begin
        done_d = bit_near && last_stop;
        if (bit_end) begin
          if (!last_stop) begin
            load   = 1'b1;
            scnt_d = 1'b1;
          end else if (en && !f_empty) begin
            state_d = POP;
            rd_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      par     <= 1'b0;
      bcnt    <= '0;
      scnt    <= 1'b0;
      tx      <= TX_IDLE_LVL;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      par     <= par_d;
      bcnt    <= bcnt_d;
      scnt    <= scnt_d;
      tx      <= tx_d;
      rd_en   <= rd_d;
      busy    <= (state_d != IDLE);
      tx_done <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed scoreboard bench
// with a behavioural FIFO on the read side.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, en_p;
  logic       f_empty = 1'b1, f_empty_p = 1'b1;
  logic [7:0] f_out = '0, f_out_p = '0;
  logic       rd_en, tx, busy, tx_done;
  logic       rd_en_p, tx_p, busy_p, tx_done_p;

  logic       push = 1'b0, push_p = 1'b0;
  logic [7:0] pdata = '0, pdata_p = '0;
  logic [7:0] fq[$];
  logic [7:0] fqp[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_qp[$];

  int cyc = 0, fall_cyc = 0;
  int rd_cnt = 0, rd_cnt_p = 0, bad_rd = 0;
  int nchk = 0, npass = 0, nfail = 0;
  int st, ec, pe, w;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(4),
    .PARITY_EN   (0),
    .STOP_BITS   (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .f_empty(f_empty),
    .f_out  (f_out),
    .rd_en  (rd_en),
    .tx     (tx),
    .busy   (busy),
    .tx_done(tx_done)
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT(4),
    .PARITY_EN   (1),
    .STOP_BITS   (1)
  ) dut_p (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en_p),
    .f_empty(f_empty_p),
    .f_out  (f_out_p),
    .rd_en  (rd_en_p),
    .tx     (tx_p),
    .busy   (busy_p),
    .tx_done(tx_done_p)
  );

  // FIFO model feeding dut
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (f_empty) bad_rd <= bad_rd + 1;
      if (fq.size() != 0) f_out <= fq.pop_front();
    end
    if (push) fq.push_back(pdata);
    if (f_empty && fq.size() != 0) fall_cyc <= cyc + 1;
    f_empty <= (fq.size() == 0);
  end

  // FIFO model feeding dut_p
  always @(posedge clk) begin
    if (rd_en_p) begin
      rd_cnt_p <= rd_cnt_p + 1;
      if (f_empty_p) bad_rd <= bad_rd + 1;
      if (fqp.size() != 0) f_out_p <= fqp.pop_front();
    end
    if (push_p) fqp.push_back(pdata_p);
    f_empty_p <= (fqp.size() == 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    nchk++;
    assert (obs === expv) begin
      npass++;
    end else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, expv);
    end
  endtask

  // call at a negedge; one-cycle push
  task automatic push_byte(input bit p,
                           input logic [7:0] d);
    if (p) begin
      push_p  = 1'b1;
      pdata_p = d;
      exp_qp.push_back(d);
    end else begin
      push  = 1'b1;
      pdata = d;
      exp_q.push_back(d);
    end
    @(negedge clk);
    push   = 1'b0;
    push_p = 1'b0;
  endtask

  task automatic check_frame(input bit p,
                             output int s,
                             output int e);
    logic [7:0]  d;
    logic [11:0] bits;
    logic        t, dn, last;
    int          nb, k;
    string       tg;
    s = -1;
    e = -1;
    if (p ? exp_qp.size() == 0 : exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    d = p ? exp_qp.pop_front() : exp_q.pop_front();
    nb = p ? 11 : 10;
    if (p) bits = {1'b1, ^d, d, 1'b0};
    else   bits = {2'b11, d, 1'b0};
    k = 0;
    do begin
      @(negedge clk);
      k++;
      t = p ? tx_p : tx;
    end while (t !== 1'b0 && k < 100);
    if (t !== 1'b0) begin
      chk("start_timeout", 0, 1);
      return;
    end
    s = cyc;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        t    = p ? tx_p : tx;
        dn   = p ? tx_done_p : tx_done;
        last = (i == nb - 1) && (c == 3);
        tg = $sformatf("frame%0d_%02h_bit%0d_c%0d",
                       p, d, i, c);
        chk(tg, 32'({t, dn}), 32'({bits[i], last}));
      end
    end
    e = cyc;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    en_p  = 1'b1;
    repeat (2) @(negedge clk);

    // reset with 0x55 waiting in the FIFO
    push_byte(0, 8'h55);
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_tx_p", 32'(tx_p), 1);
    chk("rst_no_pop", 32'(rd_cnt), 0);
    rst_n = 1'b1;
    check_frame(0, st, ec);
    repeat (4) @(negedge clk);
    chk("rst_one_pop", 32'(rd_cnt), 1);
    chk("idle_busy", 32'(busy), 0);

    // back-to-back frames
    push_byte(0, 8'h01);
    push_byte(0, 8'h80);
    push_byte(0, 8'hA5);
    check_frame(0, st, ec);
    pe = ec;
    for (int i = 0; i < 2; i++) begin
      check_frame(0, st, ec);
      chk("b2b_gap", 32'(st - pe - 1), 2);
      pe = ec;
    end
    repeat (6) @(negedge clk);
    chk("b2b_pops", 32'(rd_cnt), 4);
    chk("b2b_empty", 32'(f_empty), 1);
    chk("b2b_tx_idle", 32'(tx), 1);

    // en held low with a full FIFO
    en = 1'b0;
    for (int i = 0; i < 8; i++)
      push_byte(0, 8'(8'h30 + i * 7));
    repeat (20) @(negedge clk);
    chk("en0_pops", 32'(rd_cnt), 4);
    chk("en0_tx", 32'(tx), 1);
    chk("en0_busy", 32'(busy), 0);
    chk("en0_fifo", 32'(fq.size()), 8);
    en = 1'b1;
    fork
      check_frame(0, st, ec);
      begin
        repeat (12) @(negedge clk);
        en = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("endrop_fifo", 32'(fq.size()), 7);
    chk("endrop_pops", 32'(rd_cnt), 5);
    chk("endrop_busy", 32'(busy), 0);
    chk("endrop_tx", 32'(tx), 1);

    // drain the rest, then refill
    en = 1'b1;
    check_frame(0, st, ec);
    pe = ec;
    for (int i = 0; i < 6; i++) begin
      check_frame(0, st, ec);
      chk("drain_gap", 32'(st - pe - 1), 2);
      pe = ec;
    end
    repeat (5) @(negedge clk);
    chk("drain_idle", 32'(busy), 0);
    chk("drain_pops", 32'(rd_cnt), 12);
    chk("drain_empty", 32'(f_empty), 1);
    push_byte(0, 8'h3C);
    check_frame(0, st, ec);
    chk("refill_latency", 32'(st - fall_cyc), 3);

    // reset in the middle of D3 of 0xFF
    push_byte(0, 8'hFF);
    push_byte(0, 8'h42);
    w = 0;
    while (tx !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("mid_start", 32'(tx), 0);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame(0, st, ec);
    repeat (4) @(negedge clk);
    chk("mid_pops", 32'(rd_cnt), 15);
    chk("mid_fifo", 32'(fq.size()), 0);

    // even parity instance
    push_byte(1, 8'h07);
    check_frame(1, st, ec);
    chk("par07_len", 32'(ec - st + 1), 44);
    push_byte(1, 8'h03);
    check_frame(1, st, ec);
    chk("par03_len", 32'(ec - st + 1), 44);
    repeat (4) @(negedge clk);
    chk("par_pops", 32'(rd_cnt_p), 2);
    chk("rd_while_empty", 32'(bad_rd), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial drain stage on the read side of the 8-deep byte FIFO. Whenever enabled and the FIFO is non-empty, it pops one byte, frames it as an asynchronous serial character (start, 8 data bits LSB-first, optional even parity, stop), and shifts it out on a single line. It is the FIFO's only reader and owns `rd_en` exclusively.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit after D7.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: permits starting new frames. A frame in progress always completes.
- `f_empty`, in, 1: FIFO empty flag.
- `f_out`, in, 8: FIFO read data, valid in the cycle after the `rd_en` edge.
- `rd_en`, out, 1: registered pop strobe to the FIFO, exactly one cycle per byte.
- `tx`, out, 1: serial line, idles high.
- `busy`, out, 1: high from the POP state through the end of the stop bits.
- `tx_done`, out, 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States and their behaviour:
  - IDLE: `tx`=1. If `en` and not `f_empty`, go to POP.
  - POP: `rd_en`=1 for this cycle only. Go to LOAD.
  - LOAD: capture `f_out` into the shift register, compute parity, clear the bit counter. Go to START.
  - START: `tx`=0 for one bit time.
  - DATA: `tx`=shreg[0]. Shift right once per bit time, for 8 bits.
  - PARITY: only when `PARITY_EN`=1. `tx`=XOR of the byte, so the 1s count over data plus parity is even.
  - STOP: `tx`=1 for `STOP_BITS` bit times.
- End of STOP:
  - `tx_done`=1.
  - If `en` and not `f_empty`, go directly to POP. Otherwise go to IDLE.
- `f_empty` is sampled only in IDLE and in the last STOP cycle. `rd_en` is never asserted while `f_empty`=1.
- Bit timer:
  - Down-counter of width `$clog2(CLKS_PER_BIT)`, loaded with `CLKS_PER_BIT-1` on entry to START, DATA, PARITY and STOP.
  - Each bit ends when the counter reaches 0.
- Bit counter: 3 bits, wraps 7→0 at the DATA exit.
- `en` deasserted mid-frame: the current frame finishes normally; no further POP.
- FIFO fills to 8 while serialising: no effect; the block pops at its own rate.
- Reset asserted mid-frame:
  - `tx` goes to 1 immediately (asynchronously).
  - State returns to IDLE.
  - The byte already popped is discarded; there is no re-read.

## Timing
- Reset values: `tx`=1, `rd_en`=0, `busy`=0, `tx_done`=0, state=IDLE, shift register=0, counters=0.
- Latency from `f_empty` falling (IDLE, `en`=1) to the start bit on `tx`: 3 cycles (IDLE→POP→LOAD→START).
- Frame length in cycles: `CLKS_PER_BIT`×(10+`PARITY_EN`+`STOP_BITS`−1).
- Back-to-back frames: a fixed 2-cycle idle-high gap (POP, LOAD) between the last stop cycle and the next start bit.
- All outputs are registered. `tx` changes only on bit boundaries.

## Structure
- Package `fifo_uart_pkg`:
  - state enum `tx_state_t` {IDLE, POP, LOAD, START, DATA, PARITY, STOP};
  - `DATA_BITS`=8;
  - `TX_IDLE_LVL`=1'b1.
- One sub-module: `uart_baud_gen`, the parameterised bit-time down-counter with inputs load/enable and output `bit_end`. The FSM, shift register and parity logic stay in `fifo_uart_tx`.
- The top-level test harness instantiates the FIFO plus `fifo_uart_tx`, wired `f_out`/`f_empty`/`rd_en`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `STOP_BITS`=1.
- Reset: hold `rst_n`=0 with the FIFO holding 0x55 → `tx`=1, `rd_en`=0, `busy`=0. After release, exactly one `rd_en` pulse occurs; `tx` then shows 0,1,0,1,0,1,0,1,0,1, each level lasting 4 cycles, 40 cycles total, with `tx_done` in cycle 40.
- Back-to-back: push 0x01, 0x80, 0xA5 with `en`=1 → three frames, each separated by exactly 2 high cycles.
  - The bytes arrive in order, LSB-first.
  - Exactly three `rd_en` pulses occur, and none after the FIFO goes empty.
- Parity: with `PARITY_EN`=1, send 0x07 → parity bit 1. Send 0x03 → parity bit 0. Each frame is 44 cycles.
- `en` control: hold `en`=0 with the FIFO at 8 entries → no `rd_en` and `tx` stays high. Raise `en`, then drop it during the DATA bits of the first frame → that frame completes, the FIFO count ends at 7, and there is no second POP.
- Empty/refill: the FIFO empties mid-stream → the block returns to IDLE. Push 0x3C 5 cycles later → the start bit appears 3 cycles after `f_empty` falls.
- Reset mid-frame: assert `rst_n` during bit D3 of 0xFF → `tx`=1 within the same cycle. No frame resumes; the next frame starts with the next FIFO byte.
